// File: rtl/adder_arb_pkg.sv
// Shared constants, ID width helper and result-register state for adder_arbiter.
package adder_arb_pkg;

   localparam int ADDER_ARB_WIDTH   = 32;
   localparam int ADDER_ARB_NUM_REQ = 4;

   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic {ARB_EMPTY, ARB_FULL} arb_state_e;

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester/response bundle for adder_arbiter; rsp_ovf exists only with ADDER_ARB_OVF_EN.
interface adder_arbiter_if import adder_arb_pkg::*; #(
   parameter int WIDTH   = ADDER_ARB_WIDTH,
   parameter int NUM_REQ = ADDER_ARB_NUM_REQ
);
   localparam int ID_W = id_w(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_a;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]            req_cin;
   logic [NUM_REQ-1:0]            req_mode;
   logic                          rsp_valid;
   logic                          rsp_ready;
   logic [WIDTH-1:0]              rsp_sum;
   logic                          rsp_cout;
   logic [ID_W-1:0]               rsp_id;
`ifdef ADDER_ARB_OVF_EN
   logic                          rsp_ovf;
`endif

   modport master (
      output req_valid, req_a, req_b, req_cin, req_mode, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
`ifdef ADDER_ARB_OVF_EN
      , input rsp_ovf
`endif
   );

   modport slave (
      input  req_valid, req_a, req_b, req_cin, req_mode, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
`ifdef ADDER_ARB_OVF_EN
      , output rsp_ovf
`endif
   );

endinterface

// File: rtl/carry_look_ahead_adder.sv
// WIDTH-bit adder built from 4-bit carry-lookahead groups chained group to group.
module carry_look_ahead_adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH-1:0] g, p;
   logic [3:0]       gg, pp, c4;
   logic             carry;

   assign g = a & b;
   assign p = a ^ b;

   always_comb begin
      sum   = '0;
      gg    = '0;
      pp    = '0;
      c4    = '0;
      carry = cin;
      for (int j = 0; j < WIDTH / 4; j++) begin
         gg    = g[4*j +: 4];
         pp    = p[4*j +: 4];
         c4[0] = carry;
         c4[1] = gg[0] | (pp[0] & c4[0]);
         c4[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c4[0]);
         c4[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
               | (pp[2] & pp[1] & pp[0] & c4[0]);
         // group carry-out from group generate/propagate, not from c4[3]
         carry = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
               | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & c4[0]);
         sum[4*j +: 4] = pp ^ c4;
      end
      cout = carry;
   end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid request at or after ptr, wrapping.
module rr_arbiter import adder_arb_pkg::*; #(
   parameter int NUM_REQ = ADDER_ARB_NUM_REQ,
   parameter int ID_W    = id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_idx,
   output logic               gnt_vld
);

   logic            found;
   logic [ID_W-1:0] cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
      end
      gnt_vld = en && found;
      if (gnt_vld) gnt[gnt_idx] = 1'b1;
   end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one carry-lookahead adder across NUM_REQ requesters.
// Define ADDER_ARB_OVF_EN to add the registered signed-overflow output rsp_ovf.
module adder_arbiter import adder_arb_pkg::*; #(
   parameter int WIDTH   = ADDER_ARB_WIDTH,
   parameter int NUM_REQ = ADDER_ARB_NUM_REQ
) (
   input  logic            clk,
   input  logic            rst_n,
   adder_arbiter_if.slave  bus
);

   localparam int ID_W = id_w(NUM_REQ);

   arb_state_e       state_q, state_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic               slot_free, gnt_vld, op_cin, add_cout;
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_idx;
   logic [WIDTH-1:0]   op_a, op_b, add_sum;

   // rst_n term keeps every req_ready low while reset is held
   assign slot_free = rst_n && ((state_q == ARB_EMPTY) || bus.rsp_ready);

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .req     (bus.req_valid),
      .ptr     (rr_ptr_q),
      .en      (slot_free),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   assign bus.req_ready = gnt;

   assign op_a   = bus.req_a[gnt_idx];
   assign op_b   = bus.req_b[gnt_idx] ^ {WIDTH{bus.req_mode[gnt_idx]}};
   assign op_cin = bus.req_cin[gnt_idx];

   carry_look_ahead_adder #(.WIDTH(WIDTH)) u_add (
      .a    (op_a),
      .b    (op_b),
      .cin  (op_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

`ifdef ADDER_ARB_OVF_EN
   logic ovf_q, ovf_d;
`endif

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
`ifdef ADDER_ARB_OVF_EN
      ovf_d    = ovf_q;
`endif
      if (gnt_vld) begin
         state_d  = ARB_FULL;
         sum_d    = add_sum;
         cout_d   = add_cout;
         id_d     = gnt_idx;
         rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
`ifdef ADDER_ARB_OVF_EN
         ovf_d    = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_sum[WIDTH-1] != op_a[WIDTH-1]);
`endif
      end else if (state_q == ARB_FULL && bus.rsp_ready) begin
         state_d = ARB_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ARB_EMPTY;
         rr_ptr_q <= '0;
         id_q     <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
`ifdef ADDER_ARB_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign bus.rsp_valid = (state_q == ARB_FULL);
   assign bus.rsp_sum   = sum_q;
   assign bus.rsp_cout  = cout_q;
   assign bus.rsp_id    = id_q;
`ifdef ADDER_ARB_OVF_EN
   assign bus.rsp_ovf   = ovf_q;
`endif

endmodule
